bf16_to_fp32_unpacker: RTL
==========================

Name: bf16_to_fp32_unpacker

Overview:
Streaming widening converter: accepts 32-bit words carrying one or two BF16 values and emits one FP32 value per output handshake.
- Sits on the result path of the BF16 accelerator, returning BF16 results to the FP32 domain. It is the inverse of the FP32-to-BF16 converter.
- Widening is exact except for NaN canonicalisation and optional flush-to-zero, so no rounding logic is needed.

Parameters:
CANON_NAN, 1, 1 = every NaN output is 32'h7FC00000; 0 = quiet NaN preserving sign and payload.
FTZ, 0, 1 = subnormal BF16 inputs flush to signed zero and raise underflow.
CNT_W, 16, width of the saturating conversion counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
in_valid  in  1  input word valid.
in_ready  out  1  unpacker can accept the word this cycle.
in_data  in  32  lane0 = [15:0], lane1 = [31:16], both BF16.
in_single  in  1  1 = only lane0 meaningful; lane1 is ignored.
out_valid  out  1  out_* fields hold a result.
out_ready  in  1  consumer accepts the result this cycle.
out_data  out  32  FP32 result.
out_invalid  out  1  source lane was a signaling NaN.
out_underflow  out  1  source lane was subnormal and FTZ=1.
conv_count  out  CNT_W  saturating count of output handshakes.

Behaviour:
- Reset (asynchronous on reset=0): state=IDLE, out_valid=0, out_data=0, out_invalid=0, out_underflow=0, conv_count=0, held word and single flag cleared.
  - A pending lane1 is discarded.
  - in_ready is 0 while reset is asserted.
- Handshakes:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_* is registered and stable while out_valid=1 and out_ready=0.
  - in_ready is combinational from state and out_ready; it never depends on in_valid.
- FSM states IDLE, L0 (emitting lane0), L1 (emitting lane1):
  - IDLE: in_ready=1, out_valid=0. On input transfer: capture word and single flag, load conv(lane0) into out regs, go to L0. Latency is 1 cycle.
  - L0, single=1: in_ready=out_ready.
    - Output transfer with input transfer: load conv(new lane0), stay in L0.
    - Output transfer without input transfer: go to IDLE.
  - L0, single=0: in_ready=0. On output transfer: load conv(held lane1), go to L1.
  - L1: in_ready=out_ready.
    - Output transfer with input transfer: load conv(new lane0), go to L0.
    - Output transfer without input transfer: go to IDLE.
  - Sustained throughput: one FP32 per cycle; a pair word takes 2 cycles, a single word 1 cycle.
- conv(x), with s=x[15], e=x[14:7], m=x[6:0]:
  - e=FF, m!=0 (NaN):
    - CANON_NAN=1: output 32'h7FC00000.
    - CANON_NAN=0: output {s, 8'hFF, m|7'h40, 16'h0}.
    - out_invalid = ~m[6].
  - e=FF, m=0 (Inf): output {s, 8'hFF, 23'h0}.
  - e=0, m=0 (zero): output {s, 31'h0}.
  - e=0, m!=0 (subnormal):
    - FTZ=1: output {s, 31'h0}, out_underflow=1.
    - FTZ=0: output {s, 8'h00, m, 16'h0} (exact), out_underflow=0.
  - Normal: output {s, e, m, 16'h0}.
  - Flags are 0 unless stated above.
- conv_count: increments on each output transfer and saturates at all-ones (no wrap).
- Stalls: in_data changes while in_ready=0 are ignored. The held word is used for lane1.

Decomposition:
- Package bf16_pkg, shared with the FP32-to-BF16 converter:
  - Typedefs: bf16_t struct {sign, exp[7:0], man[6:0]}; fp32_t struct {sign, exp[7:0], man[22:0]}.
  - Constants: BF16_EXP_MAX=8'hFF, FP32_CANON_QNAN=32'h7FC00000, BF16_CANON_QNAN=16'h7FC0.
  - FSM state enum unpack_state_e.
- Sub-module bf16_to_fp32_lane: purely combinational conv(). Inputs are bf16_t plus the CANON_NAN and FTZ parameters; outputs are fp32_t, invalid and underflow. The top level holds the FSM, registers and counter.

Test Plan:
1. Pair word in_data=32'hC0003F80, single=0, out_ready=1 held. Required response:
   - out 32'h3F800000 one cycle after accept, then 32'hC0000000 the next cycle.
   - in_ready=0 during the first of those cycles.
   - conv_count=2.
2. Signaling and quiet NaNs:
   - Single 16'h7F81, CANON_NAN=1 -> 32'h7FC00000, out_invalid=1.
   - 16'hFFC1 -> 32'h7FC00000, out_invalid=0.
   - CANON_NAN=0, 16'h7F81 -> 32'h7FC10000, out_invalid=1.
3. Subnormals:
   - 16'h0001, FTZ=0 -> 32'h00010000, out_underflow=0.
   - FTZ=1 -> 32'h00000000, out_underflow=1.
   - 16'h8001, FTZ=1 -> 32'h80000000.
4. Backpressure: pair word accepted, then out_ready=0 for 5 cycles. Required response:
   - out_valid=1 and out_data=lane0 result, stable throughout.
   - in_ready=0; conv_count unchanged.
   - Releasing out_ready yields lane0, then lane1, in order.
5. Back-to-back traffic: in_valid=1 and out_ready=1 continuously, alternating single and pair words. Required response: out_valid stays high every cycle, with no bubbles and no duplicated or dropped lanes.
6. Reset and saturation:
   - Reset asserted while in L0 of a pair -> immediately out_valid=0 and conv_count=0; after release in_ready=1 and lane1 is never emitted.
   - Separately, CNT_W=4 with 20 transfers -> conv_count holds 4'hF.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared BF16/FP32 types and constants for the BF16 accelerator converters.
package bf16_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] man;
  } bf16_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam logic [7:0]  BF16_EXP_MAX    = 8'hFF;
  localparam logic [31:0] FP32_CANON_QNAN = 32'h7FC00000;
  localparam logic [15:0] BF16_CANON_QNAN = 16'h7FC0;

  // IDLE: nothing held; L0: presenting lane0; L1: presenting lane1 of a pair
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_L0   = 2'd1,
    ST_L1   = 2'd2
  } unpack_state_e;

endpackage

// File: rtl/bf16_to_fp32_lane.sv
// Combinational BF16 -> FP32 widening of one lane. Exact apart from NaN
// canonicalisation and optional flush-to-zero of subnormals.
module bf16_to_fp32_lane
  import bf16_pkg::*;
#(
  parameter bit CANON_NAN = 1'b1,
  parameter bit FTZ       = 1'b0
) (
  input  bf16_t in_val,
  output fp32_t out_val,
  output logic  invalid,
  output logic  underflow
);

  // Default is the exact widening (covers normal, zero, inf, unflushed subnormal)
  always_comb begin
    out_val   = '{sign: in_val.sign, exp: in_val.exp, man: {in_val.man, 16'h0000}};
    invalid   = 1'b0;
    underflow = 1'b0;
    if (in_val.exp == BF16_EXP_MAX) begin
      if (in_val.man != 7'h00) begin
        // quiet bit clear means the source was a signaling NaN
        invalid = ~in_val.man[6];
        if (CANON_NAN) begin
          out_val = fp32_t'(FP32_CANON_QNAN);
        end else begin
          out_val.man = {in_val.man | 7'h40, 16'h0000};
        end
      end
    end else if ((in_val.exp == 8'h00) && (in_val.man != 7'h00) && FTZ) begin
      out_val.man = '0;
      underflow   = 1'b1;
    end
  end

endmodule

// File: rtl/bf16_to_fp32_unpacker.sv
// Streaming unpacker: 32-bit words carrying one or two BF16 lanes in,
// one registered FP32 result per output handshake.
// Handshake: a transfer happens on a rising edge where valid & ready are both 1;
// out_* stays stable while out_valid=1 and out_ready=0; in_ready never looks at in_valid.
module bf16_to_fp32_unpacker
  import bf16_pkg::*;
#(
  parameter bit CANON_NAN = 1'b1,
  parameter bit FTZ       = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_single,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_invalid,
  output logic             out_underflow,
  output logic [CNT_W-1:0] conv_count,
  output logic [1:0]       fsm_state
);

  unpack_state_e state;
  logic [15:0]   held_lane1;
  logic          held_single;
  logic          in_xfer;
  logic          out_xfer;
  bf16_t         conv_src;
  fp32_t         conv_res;
  logic          conv_invalid;
  logic          conv_underflow;

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign fsm_state = state;

  // Input readiness: free in IDLE, and whenever the current result leaves with no lane1 pending
  always_comb begin
    in_ready = 1'b0;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_L0:   in_ready = held_single & out_ready;
      ST_L1:   in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    if (!reset) in_ready = 1'b0;
  end

  // Converter source: held lane1 while finishing a pair, otherwise the incoming lane0
  always_comb begin
    conv_src = bf16_t'(in_data[15:0]);
    if ((state == ST_L0) && !held_single) conv_src = bf16_t'(held_lane1);
  end

  bf16_to_fp32_lane #(
    .CANON_NAN (CANON_NAN),
    .FTZ       (FTZ)
  ) u_lane (
    .in_val    (conv_src),
    .out_val   (conv_res),
    .invalid   (conv_invalid),
    .underflow (conv_underflow)
  );

  // Unpack FSM with registered output fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_invalid   <= 1'b0;
      out_underflow <= 1'b0;
      held_lane1    <= '0;
      held_single   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_xfer) begin
            held_lane1    <= in_data[31:16];
            held_single   <= in_single;
            out_data      <= conv_res;
            out_invalid   <= conv_invalid;
            out_underflow <= conv_underflow;
            out_valid     <= 1'b1;
            state         <= ST_L0;
          end
        end
        ST_L0: begin
          if (out_xfer) begin
            if (!held_single) begin
              out_data      <= conv_res;
              out_invalid   <= conv_invalid;
              out_underflow <= conv_underflow;
              state         <= ST_L1;
            end else if (in_xfer) begin
              held_lane1    <= in_data[31:16];
              held_single   <= in_single;
              out_data      <= conv_res;
              out_invalid   <= conv_invalid;
              out_underflow <= conv_underflow;
            end else begin
              out_valid <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end
        ST_L1: begin
          if (out_xfer) begin
            if (in_xfer) begin
              held_lane1    <= in_data[31:16];
              held_single   <= in_single;
              out_data      <= conv_res;
              out_invalid   <= conv_invalid;
              out_underflow <= conv_underflow;
              state         <= ST_L0;
            end else begin
              out_valid <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating count of output handshakes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conv_count <= '0;
    end else if (out_xfer && (conv_count != {CNT_W{1'b1}})) begin
      conv_count <= conv_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
